// File: rtl/nx_event_interrupt_servicer.sv
// nx_event_interrupt_servicer
// Register-bus initiator for one event-interrupt register block: reads the
// status register on a level interrupt, hands the vector to a consumer,
// write-1-to-clears the dispatched bits, then re-arms after a short holdoff.
// Also programs the mask register on request.
//
// Optional feature macro: NX_INT_SVC_TIMEOUT_EN
//   defined   -> bus accesses abort after TIMEOUT_CYCLES cycles without ack,
//                pulsing timeout_err
//   undefined -> the block waits for ack indefinitely, timeout_err stays 0
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high (mask_cfg_valid/mask_cfg_ready, evt_valid/evt_ready). Once
// valid is raised it is held, with its payload stable, until that edge.
// Bus strobes are held until ack and drop on the cycle after ack.
module nx_event_interrupt_servicer #(
  parameter int N_ADDR_BITS    = 16,
  parameter int N_INT_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   int_in,
  output logic [N_ADDR_BITS-1:0] reg_addr,
  output logic                   rd_stb,
  output logic                   wr_stb,
  output logic [N_INT_BITS-1:0]  wr_data,
  input  logic [N_INT_BITS-1:0]  rd_data,
  input  logic                   ack,
  input  logic                   mask_cfg_valid,
  input  logic [N_INT_BITS-1:0]  mask_cfg,
  output logic                   mask_cfg_ready,
  output logic                   evt_valid,
  output logic [N_INT_BITS-1:0]  evt_vec,
  input  logic                   evt_ready,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [2:0]             state_dbg
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MASK_WR  = 3'd1;
  localparam logic [2:0] S_STAT_RD  = 3'd2;
  localparam logic [2:0] S_DISPATCH = 3'd3;
  localparam logic [2:0] S_CLR_WR   = 3'd4;
  localparam logic [2:0] S_HOLDOFF  = 3'd5;

  logic [2:0]            state;
  logic [N_INT_BITS-1:0] status;
  logic                  hold_cnt;
  logic                  tmo_hit;

  assign state_dbg = state;

`ifdef NX_INT_SVC_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        waiting;

  assign waiting = (state == S_MASK_WR) || (state == S_STAT_RD) || (state == S_CLR_WR);
  assign tmo_hit = waiting && !ack && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Count stalled bus cycles; any state change (ack or abort) clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (waiting && !ack && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  logic [15:0] unused_tmo_limit;

  assign tmo_hit          = 1'b0;
  assign unused_tmo_limit = 16'(TIMEOUT_CYCLES);
`endif

  // Service FSM; every output is a register updated together with the state.
  // wr_data doubles as the mask latch while MASK_WR is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      status         <= '0;
      hold_cnt       <= 1'b0;
      reg_addr       <= '0;
      rd_stb         <= 1'b0;
      wr_stb         <= 1'b0;
      wr_data        <= '0;
      evt_valid      <= 1'b0;
      evt_vec        <= '0;
      busy           <= 1'b0;
      mask_cfg_ready <= 1'b1;
      timeout_err    <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      case (state)
        S_IDLE: begin
          if (mask_cfg_valid) begin
            state          <= S_MASK_WR;
            reg_addr       <= N_ADDR_BITS'(2);
            wr_data        <= mask_cfg;
            wr_stb         <= 1'b1;
            busy           <= 1'b1;
            mask_cfg_ready <= 1'b0;
          end else if (int_in) begin
            state          <= S_STAT_RD;
            reg_addr       <= N_ADDR_BITS'(1);
            rd_stb         <= 1'b1;
            busy           <= 1'b1;
            mask_cfg_ready <= 1'b0;
          end
        end
        S_MASK_WR: begin
          if (ack || tmo_hit) begin
            state          <= S_IDLE;
            wr_stb         <= 1'b0;
            busy           <= 1'b0;
            mask_cfg_ready <= 1'b1;
          end
        end
        S_STAT_RD: begin
          if (ack) begin
            rd_stb <= 1'b0;
            status <= rd_data;
            if (rd_data != '0) begin
              state     <= S_DISPATCH;
              evt_valid <= 1'b1;
              evt_vec   <= rd_data;
            end else begin
              // Spurious interrupt: nothing to report, just let int_in settle.
              state    <= S_HOLDOFF;
              hold_cnt <= 1'b0;
            end
          end else if (tmo_hit) begin
            state          <= S_IDLE;
            rd_stb         <= 1'b0;
            busy           <= 1'b0;
            mask_cfg_ready <= 1'b1;
          end
        end
        S_DISPATCH: begin
          if (evt_ready) begin
            state     <= S_CLR_WR;
            evt_valid <= 1'b0;
            reg_addr  <= '0;
            wr_data   <= status;
            wr_stb    <= 1'b1;
          end
        end
        S_CLR_WR: begin
          if (ack || tmo_hit) begin
            state    <= S_HOLDOFF;
            wr_stb   <= 1'b0;
            hold_cnt <= 1'b0;
          end
        end
        S_HOLDOFF: begin
          // Two cycles: one for the target's clear, one for its registered int_out.
          if (hold_cnt) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            mask_cfg_ready <= 1'b1;
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        default: begin
          state          <= S_IDLE;
          rd_stb         <= 1'b0;
          wr_stb         <= 1'b0;
          evt_valid      <= 1'b0;
          busy           <= 1'b0;
          mask_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nx_event_interrupt_servicer.sv
// tb_nx_event_interrupt_servicer
// Directed bench with a behavioural target register block (raw/mask,
// combinational ack, registered int_out) and a scoreboard of expected bus
// accesses and dispatched events. Honours NX_INT_SVC_TIMEOUT_EN.
module tb_nx_event_interrupt_servicer;

  localparam int W = 34;  // {kind[1:0], addr[15:0], data[15:0]}
  localparam logic [1:0] K_RD  = 2'd0;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_EVT = 2'd2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MASK_WR  = 3'd1;
  localparam logic [2:0] S_STAT_RD  = 3'd2;
  localparam logic [2:0] S_DISPATCH = 3'd3;
  localparam logic [2:0] S_HOLDOFF  = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        int_in;
  logic [15:0] reg_addr;
  logic        rd_stb, wr_stb;
  logic [15:0] wr_data, rd_data;
  logic        ack;
  logic        mask_cfg_valid = 1'b0;
  logic [15:0] mask_cfg = '0;
  logic        mask_cfg_ready;
  logic        evt_valid;
  logic [15:0] evt_vec;
  logic        evt_ready = 1'b1;
  logic        busy, timeout_err;
  logic [2:0]  state_dbg;

  // ---------------- target model ----------------
  logic [15:0] raw = '0;
  logic [15:0] mask_m = 16'hFFFF;
  logic        int_q = 1'b0;
  logic [15:0] fire = '0;
  logic        int_force = 1'b0;
  logic        ack_en = 1'b1;

  assign int_in  = int_q | int_force;
  assign ack     = ack_en && (rd_stb || wr_stb);
  assign rd_data = (rd_stb && reg_addr == 16'd1) ? (raw & mask_m) : 16'hDEAD;

  always @(posedge clk) begin
    raw <= (raw & ~((wr_stb && ack && reg_addr == 16'd0) ? wr_data : 16'h0)) | fire;
    if (wr_stb && ack && reg_addr == 16'd2) mask_m <= wr_data;
    int_q <= |(raw & mask_m);
  end

  nx_event_interrupt_servicer #(
    .N_ADDR_BITS(16), .N_INT_BITS(16), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .int_in(int_in), .reg_addr(reg_addr),
    .rd_stb(rd_stb), .wr_stb(wr_stb), .wr_data(wr_data), .rd_data(rd_data),
    .ack(ack), .mask_cfg_valid(mask_cfg_valid), .mask_cfg(mask_cfg),
    .mask_cfg_ready(mask_cfg_ready), .evt_valid(evt_valid), .evt_vec(evt_vec),
    .evt_ready(evt_ready), .busy(busy), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s: observed %h expected nothing (queue empty)", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(obs), 64'(e));
    end
  endtask

  task automatic push_service(input logic [15:0] vec);
    exp_q.push_back({K_RD, 16'd1, 16'h0});
    exp_q.push_back({K_EVT, 16'd0, vec});
    exp_q.push_back({K_WR, 16'd0, vec});
  endtask

  // Monitor: completed bus accesses and event handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_stb && ack)         pop_check("bus_read",  {K_RD, reg_addr, 16'h0});
      if (wr_stb && ack)         pop_check("bus_write", {K_WR, reg_addr, wr_data});
      if (evt_valid && evt_ready) pop_check("event",    {K_EVT, 16'd0, evt_vec});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((busy || int_in) && n < 60) begin
      tick();
      n++;
    end
    check(tag, 64'(n < 60), 64'd1);
  endtask

  task automatic wait_sig(input string tag, input int which);
    int n = 0;
    while (!((which == 0) ? rd_stb : evt_valid) && n < 30) begin
      tick();
      n++;
    end
    check(tag, 64'(n < 30), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs",
          {rd_stb, wr_stb, evt_valid, busy, timeout_err, mask_cfg_ready, reg_addr, wr_data, evt_vec},
          {6'b000001, 16'h0, 16'h0, 16'h0});
    check("reset_state", 64'(state_dbg), 64'(S_IDLE));
    rst = 1'b0;
    tick();

    // Basic service with exact latency
    push_service(16'h0005);
    fire = 16'h0005; tick(); fire = '0;
    tick();                                     // cycle T: int_in high in IDLE
    check("basic_int_T", 64'(int_in), 64'd1);
    tick();
    check("basic_rd_T1", {rd_stb, wr_stb, reg_addr}, {2'b10, 16'd1});
    tick();
    check("basic_evt_T2", {evt_valid, rd_stb, evt_vec}, {2'b10, 16'h0005});
    tick();
    check("basic_wr_T3", {wr_stb, evt_valid, reg_addr, wr_data}, {2'b10, 16'd0, 16'h0005});
    tick();
    check("basic_hold_T4", {busy, wr_stb, state_dbg}, {2'b10, S_HOLDOFF});
    tick();
    check("basic_hold_T5", 64'(state_dbg), 64'(S_HOLDOFF));
    tick();
    check("basic_idle_T6", {busy, mask_cfg_ready, state_dbg}, {2'b01, S_IDLE});
    wait_quiet("basic_quiet");

    // Backpressure on the event output
    evt_ready = 1'b0;
    push_service(16'h0002);
    fire = 16'h0002; tick(); fire = '0;
    wait_sig("bp_evt_wait", 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {evt_valid, wr_stb, evt_vec}, {2'b10, 16'h0002});
      tick();
    end
    evt_ready = 1'b1;
    tick();
    check("bp_wr_after_hs", {evt_valid, wr_stb, reg_addr, wr_data}, {2'b01, 16'd0, 16'h0002});
    wait_quiet("bp_quiet");

    // Late event: bit 3 arrives after the read; only bit 0 is cleared
    push_service(16'h0001);
    push_service(16'h0008);
    fire = 16'h0001; tick(); fire = '0;
    wait_sig("late_rd_wait", 0);
    fire = 16'h0008; tick(); fire = '0;
    check("late_evt_first", {evt_valid, evt_vec}, {1'b1, 16'h0001});
    wait_quiet("late_quiet");

    // Spurious interrupt: status reads zero
    exp_q.push_back({K_RD, 16'd1, 16'h0});
    int_force = 1'b1; tick(); int_force = 1'b0;
    check("spur_rd", {rd_stb, reg_addr}, {1'b1, 16'd1});
    tick();
    check("spur_hold1", {evt_valid, wr_stb, rd_stb, state_dbg}, {3'b000, S_HOLDOFF});
    tick();
    check("spur_hold2", {evt_valid, wr_stb, state_dbg}, {2'b00, S_HOLDOFF});
    tick();
    check("spur_idle", {busy, state_dbg}, {1'b0, S_IDLE});

    // Mask request wins over a simultaneous interrupt
    exp_q.push_back({K_WR, 16'd2, 16'h00F0});
    push_service(16'h0010);
    fire = 16'h0010; mask_cfg = 16'h00F0; mask_cfg_valid = 1'b1; int_force = 1'b1;
    tick();
    fire = '0; mask_cfg_valid = 1'b0; int_force = 1'b0;
    check("mask_first", {state_dbg, wr_stb, rd_stb, mask_cfg_ready, reg_addr, wr_data},
          {S_MASK_WR, 3'b100, 16'd2, 16'h00F0});
    wait_quiet("mask_quiet");
    exp_q.push_back({K_WR, 16'd2, 16'hFFFF});
    mask_cfg = 16'hFFFF; mask_cfg_valid = 1'b1;
    tick();
    mask_cfg_valid = 1'b0;
    wait_quiet("mask_restore_quiet");

    // Reset while in DISPATCH: no clear write, outputs back to reset values
    evt_ready = 1'b0;
    push_service(16'h0004);
    fire = 16'h0004; tick(); fire = '0;
    wait_sig("rst_evt_wait", 1);
    check("rst_in_dispatch", 64'(state_dbg), 64'(S_DISPATCH));
    rst = 1'b1;
    exp_q.delete();
    push_service(16'h0004);                     // raw still pending: serviced again
    tick();
    check("rst_outputs",
          {rd_stb, wr_stb, evt_valid, busy, timeout_err, mask_cfg_ready, reg_addr, wr_data, evt_vec},
          {6'b000001, 16'h0, 16'h0, 16'h0});
    rst = 1'b0;
    evt_ready = 1'b1;
    wait_quiet("rst_quiet");

`ifdef NX_INT_SVC_TIMEOUT_EN
    // Ack stuck low in STAT_RD: abort after 4 cycles, then service normally
    push_service(16'h0001);
    ack_en = 1'b0;
    fire = 16'h0001; tick(); fire = '0;
    wait_sig("tmo_rd_wait", 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tmo_waiting", {rd_stb, timeout_err}, 2'b10);
    end
    tick();
    check("tmo_pulse", {rd_stb, timeout_err, state_dbg}, {2'b01, S_IDLE});
    ack_en = 1'b1;
    tick();
    check("tmo_pulse_end", {timeout_err, rd_stb}, 2'b01);
    wait_quiet("tmo_quiet");
`else
    // Ack stuck low: the block just keeps waiting, no error
    ack_en = 1'b0;
    push_service(16'h0001);
    fire = 16'h0001; tick(); fire = '0;
    wait_sig("wait_rd", 0);
    repeat (20) tick();
    check("no_timeout", {rd_stb, timeout_err, state_dbg}, {2'b10, S_STAT_RD});
    ack_en = 1'b1;
    wait_quiet("no_tmo_quiet");
`endif

    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
